// File: rtl/gradient_writer_if.sv
// Bundle between gradient_writer and the image / x_grad / y_grad BRAMs plus its start/busy/done control.
// The master modport is the gradient writer; the slave modport is the surrounding memory/control side.
interface gradient_writer_if #(
  parameter int WIDTH     = 4,
  parameter int HEIGHT    = 4,
  parameter int BIT_DEPTH = 8
);
  localparam int AW = $clog2(WIDTH * HEIGHT);

  logic                 start;
  logic [AW-1:0]        pixel_read_addr;
  logic [BIT_DEPTH-1:0] pixel_in;
  logic [AW-1:0]        x_write_addr;
  logic                 x_write_valid;
  logic [BIT_DEPTH-1:0] x_pixel_out;
  logic [AW-1:0]        y_write_addr;
  logic                 y_write_valid;
  logic [BIT_DEPTH-1:0] y_pixel_out;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, pixel_in,
    output pixel_read_addr, x_write_addr, x_write_valid, x_pixel_out,
           y_write_addr, y_write_valid, y_pixel_out, busy, done
  );

  modport slave (
    output start, pixel_in,
    input  pixel_read_addr, x_write_addr, x_write_valid, x_pixel_out,
           y_write_addr, y_write_valid, y_pixel_out, busy, done
  );
endinterface

// File: rtl/gradient_writer.sv
// Walks the image BRAM in raster order, reads clamped L/R/U/D neighbours per pixel and
// writes floored central-difference x/y gradients to the gradient BRAMs, then pulses done.
module gradient_writer #(
  parameter int WIDTH        = 4,
  parameter int HEIGHT       = 4,
  parameter int BIT_DEPTH    = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  gradient_writer_if.master bus
);
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int XW   = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
  localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PH_W = $clog2(READ_LATENCY + 5);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t               state_q, state_d;
  logic [PH_W-1:0]      phase;
  logic [XW-1:0]        px, nxt_px;
  logic [YW-1:0]        py, nxt_py;
  logic                 last_px, last_py, rd_end, d_cap;
  int                   nb_x, nb_y, nb_sel;
  logic [BIT_DEPTH-1:0] l_p1, r_p1, u_p1;

  function automatic logic [AW-1:0] nb_addr(input int x, input int y, input int sel);
    int nx;
    int ny;
    nx = x;
    ny = y;
    case (sel)
      0:       nx = (x > 0) ? x - 1 : 0;
      1:       nx = (x < WIDTH - 1) ? x + 1 : WIDTH - 1;
      2:       ny = (y > 0) ? y - 1 : 0;
      default: ny = (y < HEIGHT - 1) ? y + 1 : HEIGHT - 1;
    endcase
    return AW'(ny * WIDTH + nx);
  endfunction

  // One extra bit holds the full unsigned difference; the arithmetic shift floors toward -inf.
  function automatic logic [BIT_DEPTH-1:0] grad(input logic [BIT_DEPTH-1:0] hi,
                                                input logic [BIT_DEPTH-1:0] lo);
    logic signed [BIT_DEPTH:0] diff;
    diff = $signed({1'b0, hi}) - $signed({1'b0, lo});
    diff = diff >>> 1;
    return diff[BIT_DEPTH-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    last_px = (int'(px) == WIDTH - 1);
    last_py = (int'(py) == HEIGHT - 1);
    rd_end  = (phase == PH_W'(3));
    d_cap   = (phase == PH_W'(3 + READ_LATENCY));
    nxt_px  = last_px ? '0 : px + XW'(1);
    nxt_py  = last_px ? (last_py ? '0 : py + YW'(1)) : py;
    case (state_q)
      IDLE:    if (bus.start) state_d = READ;
      READ:    if (d_cap) state_d = WRITE;
               else if (rd_end) state_d = WAIT;
      WAIT:    if (d_cap) state_d = WRITE;
      WRITE:   state_d = (last_px && last_py) ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Entering READ from IDLE/WRITE starts a new pixel at the L neighbour.
    nb_sel = (state_q == READ) ? int'(phase) + 1 : 0;
    nb_x   = (state_q == WRITE) ? int'(nxt_px) : int'(px);
    nb_y   = (state_q == WRITE) ? int'(nxt_py) : int'(py);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q             <= IDLE;
      phase               <= '0;
      px                  <= '0;
      py                  <= '0;
      bus.pixel_read_addr <= '0;
      bus.x_write_addr    <= '0;
      bus.x_write_valid   <= 1'b0;
      bus.x_pixel_out     <= '0;
      bus.y_write_addr    <= '0;
      bus.y_write_valid   <= 1'b0;
      bus.y_pixel_out     <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
    end else begin
      state_q <= state_d;
      phase   <= (state_q == READ || state_q == WAIT) ? phase + PH_W'(1) : '0;
      if (state_q == WRITE) begin
        px <= nxt_px;
        py <= nxt_py;
      end
      if (state_d == READ) bus.pixel_read_addr <= nb_addr(nb_x, nb_y, nb_sel);
      bus.x_write_valid <= (state_d == WRITE);
      bus.y_write_valid <= (state_d == WRITE);
      // The D sample is live on pixel_in at the edge that enters WRITE.
      if (state_d == WRITE) begin
        bus.x_write_addr <= AW'(int'(py) * WIDTH + int'(px));
        bus.y_write_addr <= AW'(int'(py) * WIDTH + int'(px));
        bus.x_pixel_out  <= grad(r_p1, l_p1);
        bus.y_pixel_out  <= grad(bus.pixel_in, u_p1);
      end
      bus.busy <= (state_d != IDLE);
      bus.done <= (state_d == DONE);
    end
  end

  // --- neighbour capture stage: sample n returns READ_LATENCY cycles after its address ---
  always_ff @(posedge clk_in) begin
    if (state_q == READ || state_q == WAIT) begin
      if (phase == PH_W'(READ_LATENCY))     l_p1 <= bus.pixel_in;
      if (phase == PH_W'(READ_LATENCY + 1)) r_p1 <= bus.pixel_in;
      if (phase == PH_W'(READ_LATENCY + 2)) u_p1 <= bus.pixel_in;
    end
  end
endmodule
